// File: rtl/imem_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte stream,
// writes them into instruction memory, verifies a payload checksum, then releases the CPU.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [3:0] {
    S_HDR_HI, S_HDR_LO, S_CHECK_LEN, S_W_HI, S_W_LO, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  state_t          state, state_next;
  logic [15:0]     len;
  logic [7:0]      sum;
  logic [7:0]      hi;
  logic [ADDR_W:0] index;
  logic            accept;
  logic            len_too_big;
  logic [15:0]     index_inc;

  assign accept      = in_valid && in_ready;
  assign len_too_big = {1'b0, len} > MAX_WORDS;
  assign index_inc   = 16'(index) + 16'd1;

  always_comb begin
    state_next = state;
    case (state)
      S_HDR_HI:    if (accept) state_next = S_HDR_LO;
      S_HDR_LO:    if (accept) state_next = S_CHECK_LEN;
      S_CHECK_LEN: begin
        if (len_too_big)    state_next = S_ERROR;
        else if (len == '0) state_next = S_CSUM;
        else                state_next = S_W_HI;
      end
      S_W_HI:      if (accept) state_next = S_W_LO;
      S_W_LO:      if (accept) state_next = S_WRITE;
      S_WRITE:     state_next = (index_inc == len) ? S_CSUM : S_W_HI;
      S_CSUM:      if (accept) state_next = (in_data == sum) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:     if (start) state_next = S_HDR_HI;
      default:     state_next = S_HDR_HI;
    endcase
  end

  // Status outputs are derived from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_HDR_HI;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      words_loaded <= '0;
      len          <= '0;
      sum          <= '0;
      hi           <= '0;
      index        <= '0;
    end else begin
      state    <= state_next;
      in_ready <= state_next inside {S_HDR_HI, S_HDR_LO, S_W_HI, S_W_LO, S_CSUM};
      imem_we  <= (state_next == S_WRITE);
      cpu_rst  <= (state_next != S_DONE);
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERROR);
      case (state)
        S_HDR_HI: if (accept) len[15:8] <= in_data;
        S_HDR_LO: if (accept) begin
          len[7:0] <= in_data;
          sum      <= '0;
          index    <= '0;
        end
        S_CHECK_LEN: if (len_too_big) err_code <= 2'd1;
        S_W_HI: if (accept) begin
          hi  <= in_data;
          sum <= sum + in_data;
        end
        S_W_LO: if (accept) begin
          sum        <= sum + in_data;
          imem_addr  <= index[ADDR_W-1:0];
          imem_wdata <= {hi, in_data};
        end
        S_WRITE: begin
          index        <= index + ONE;
          words_loaded <= words_loaded + ONE;
        end
        S_CSUM: if (accept && (in_data != sum)) err_code <= 2'd2;
        S_DONE,
        S_ERROR: if (start) begin
          err_code     <= 2'd0;
          words_loaded <= '0;
          sum          <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames against a byte-position model of the loader, compared every cycle,
// plus literal end-of-frame expectations.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 1 << ADDR_W;

  typedef logic [7:0] byteq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, imem_we, cpu_rst, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int vecs  = 0;
  int fails = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks bytes consumed in the frame and the few idle cycles the loader inserts.
  int         m_pos, m_n, m_words, m_hold, m_code, m_addr, m_wdata;
  logic [7:0] m_sum, m_hi;
  bit         m_ready, m_we, m_done, m_err, armed;
  int         we_total = 0;
  int         acc_total = 0;
  logic [15:0] mem [MAX_WORDS];

  initial begin
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("in_ready", int'(in_ready), int'(m_ready));
        chk("imem_we", int'(imem_we), int'(m_we));
        chk("imem_addr", int'(imem_addr), m_addr);
        chk("imem_wdata", int'(imem_wdata), m_wdata);
        chk("done", int'(done), int'(m_done));
        chk("error", int'(error), int'(m_err));
        chk("err_code", int'(err_code), m_code);
        chk("cpu_rst", int'(cpu_rst), int'(!m_done));
        chk("words_loaded", int'(words_loaded), m_words);
        if (imem_we) begin
          mem[imem_addr] = imem_wdata;
          we_total++;
        end
      end
      if (rst) begin
        m_pos = 0; m_n = 0; m_words = 0; m_hold = 0; m_code = 0; m_addr = 0; m_wdata = 0;
        m_sum = 8'h00; m_hi = 8'h00;
        m_ready = 1'b0; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
        armed = 1'b1;
      end else if (m_hold == 1) begin
        m_hold = 0;
        if (m_n > MAX_WORDS) begin
          m_err = 1'b1; m_code = 1;
        end else m_ready = 1'b1;
      end else if (m_hold == 2) begin
        m_hold = 0; m_we = 1'b0; m_words++; m_ready = 1'b1;
      end else if (m_done || m_err) begin
        if (start) begin
          m_done = 1'b0; m_err = 1'b0; m_code = 0; m_words = 0; m_sum = 8'h00;
          m_pos = 0; m_ready = 1'b1;
        end
      end else if (!m_ready) begin
        m_ready = 1'b1;
      end else if (in_valid) begin
        acc_total++;
        if (m_pos == 0) begin
          m_n = int'(in_data) << 8; m_pos = 1;
        end else if (m_pos == 1) begin
          m_n = m_n | int'(in_data); m_pos = 2; m_sum = 8'h00;
          m_hold = 1; m_ready = 1'b0;
        end else if (m_pos < 2 + 2 * m_n) begin
          m_sum = m_sum + in_data;
          if (((m_pos - 2) % 2) == 0) m_hi = in_data;
          else begin
            m_we = 1'b1; m_addr = (m_pos - 3) / 2; m_wdata = int'({m_hi, in_data});
            m_hold = 2; m_ready = 1'b0;
          end
          m_pos++;
        end else begin
          if (in_data == m_sum) m_done = 1'b1;
          else begin
            m_err = 1'b1; m_code = 2;
          end
          m_ready = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_data = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    vecs++; fails++;
    $display("FAIL byte_accept_timeout: byte 0x%0h not accepted, required within 50 cycles", b);
  endtask

  task automatic send_frame(input byteq_t q, input bit gaps);
    @(posedge clk); #1;
    foreach (q[i]) send_byte(q[i], gaps);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done || error) return;
    end
    vecs++; fails++;
    $display("FAIL end_timeout: done=%0b error=%0b, required one of them within 3000 cycles", done, error);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  initial begin
    byteq_t q;
    int we0, acc0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_in_ready", int'(in_ready), 0);
    chk("lit_rst_cpu_rst", int'(cpu_rst), 1);

    // Good two-word frame with random gaps
    we0 = we_total; acc0 = acc_total;
    q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_frame(q, 1'b1);
    wait_end();
    chk("lit_a_done", int'(done), 1);
    chk("lit_a_cpu_rst", int'(cpu_rst), 0);
    chk("lit_a_words", int'(words_loaded), 2);
    chk("lit_a_code", int'(err_code), 0);
    chk("lit_a_mem0", int'(mem[0]), 'h1234);
    chk("lit_a_mem1", int'(mem[1]), 'hABCD);
    chk("lit_a_writes", we_total - we0, 2);
    chk("lit_a_bytes", acc_total - acc0, 7);

    // Bad checksum
    pulse_start();
    we0 = we_total;
    q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
    send_frame(q, 1'b1);
    wait_end();
    chk("lit_b_error", int'(error), 1);
    chk("lit_b_code", int'(err_code), 2);
    chk("lit_b_cpu_rst", int'(cpu_rst), 1);
    chk("lit_b_done", int'(done), 0);
    chk("lit_b_writes", we_total - we0, 2);

    // Length 257 exceeds the memory
    pulse_start();
    we0 = we_total;
    q = {8'h01, 8'h01};
    send_frame(q, 1'b0);
    wait_end();
    chk("lit_c_code", int'(err_code), 1);
    chk("lit_c_writes", we_total - we0, 0);
    repeat (2) @(negedge clk);
    chk("lit_c_in_ready", int'(in_ready), 0);

    // Empty program, then re-arm
    pulse_start();
    we0 = we_total;
    q = {8'h00, 8'h00, 8'h00};
    send_frame(q, 1'b0);
    wait_end();
    chk("lit_d_done", int'(done), 1);
    chk("lit_d_words", int'(words_loaded), 0);
    chk("lit_d_writes", we_total - we0, 0);
    pulse_start();
    @(negedge clk);
    chk("lit_d_rearm_cpu_rst", int'(cpu_rst), 1);
    chk("lit_d_rearm_in_ready", int'(in_ready), 1);

    // Reset after the first word of a three-word frame
    q = {8'h00, 8'h03, 8'h11, 8'h22};
    send_frame(q, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("lit_e_we", int'(imem_we), 0);
    chk("lit_e_addr", int'(imem_addr), 0);
    chk("lit_e_wdata", int'(imem_wdata), 0);
    chk("lit_e_words", int'(words_loaded), 0);
    chk("lit_e_mem0_kept", int'(mem[0]), 'h1122);

    // Fresh frame with a start pulse that must be ignored
    q = {8'h00, 8'h01};
    send_frame(q, 1'b0);
    pulse_start();
    q = {8'h55, 8'hAA, 8'hFF};
    send_frame(q, 1'b1);
    wait_end();
    chk("lit_f_done", int'(done), 1);
    chk("lit_f_mem0", int'(mem[0]), 'h55AA);
    chk("lit_f_words", int'(words_loaded), 1);

    // Full memory, in_valid held high throughout; each word sums to 0xFF so checksum is 0x00
    pulse_start();
    we0 = we_total;
    q = {8'h01, 8'h00};
    for (int i = 0; i < MAX_WORDS; i++) begin
      q.push_back(8'(i));
      q.push_back(8'(255 - i));
    end
    q.push_back(8'h00);
    send_frame(q, 1'b0);
    wait_end();
    chk("lit_g_done", int'(done), 1);
    chk("lit_g_words", int'(words_loaded), 256);
    chk("lit_g_mem0", int'(mem[0]), 'h00FF);
    chk("lit_g_mem255", int'(mem[255]), 'hFF00);
    chk("lit_g_writes", we_total - we0, 256);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
